lambda_minus_pipe: RTL and testbench

Parametrised, multi-lane successor of the fixed lambda subtractor. Per lane it computes lambda = mag − rho·phi in fixed point, then pipelines the result through N_DELAY stages. A valid/ready handshake allows stalling under backpressure. A selectable mode either saturates or wraps the result, and a saturation event counter tracks clamped outputs. It sits between the magnitude/phase front end and the lambda consumer in the detection datapath.

---
 rtl/lambda_minus_pipe.sv | 131 +++++++++++++
 tb/tb_lambda_minus_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lambda_minus_pipe.sv
// lambda_minus_pipe: per-lane lambda = mag - (rho*phi >>> RHO_FRAC), narrowed
// (saturate or wrap), then carried through N_DELAY valid/ready stall stages.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with packed
// mag_in/phi_in/rho_in; out_valid/out_ready with packed lambda_out and
// per-lane sat_out; sat_clr clears sat_count, which counts output
// handshakes carrying any clamped lane.
module lambda_minus_pipe #(
  parameter int LANES    = 1,
  parameter int MAG_W    = 14,
  parameter int PHI_W    = 14,
  parameter int RHO_W    = 8,
  parameter int RHO_FRAC = 7,
  parameter int OUT_W    = 14,
  parameter int N_DELAY  = 5,
  parameter int SAT_EN   = 1,
  parameter int SATCNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*MAG_W-1:0]    mag_in,
  input  logic [LANES*PHI_W-1:0]    phi_in,
  input  logic [LANES*RHO_W-1:0]    rho_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    lambda_out,
  output logic [LANES-1:0]          sat_out,
  input  logic                      sat_clr,
  output logic [SATCNT_W-1:0]       sat_count
);

  localparam int PW = RHO_W + PHI_W + 1;
  localparam int SW = PW - RHO_FRAC;
  localparam int DW = ((MAG_W > SW) ? MAG_W : SW) + 1;
  localparam int EW = (DW > OUT_W) ? DW : OUT_W;
  localparam int LW = LANES * OUT_W;

  localparam logic signed [EW-1:0] MAXV =
    {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV =
    {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic           adv;
  logic [LW-1:0]  c_lam;
  logic [LANES-1:0] c_sat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0] rho_x;
    logic signed [PW-1:0] phi_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_s;
    logic signed [EW-1:0] mag_x;
    logic signed [EW-1:0] ps_x;
    logic signed [EW-1:0] diff;
    logic [OUT_W-1:0]     lam;
    logic                 sat;

    assign rho_x  = PW'($signed(rho_in[i*RHO_W +: RHO_W]));
    assign phi_x  = PW'({1'b0, phi_in[i*PHI_W +: PHI_W]});
    assign prod   = rho_x * phi_x;
    // arithmetic shift floors toward -inf
    assign prod_s = prod >>> RHO_FRAC;
    assign mag_x  = EW'($signed(mag_in[i*MAG_W +: MAG_W]));
    assign ps_x   = EW'(prod_s);
    assign diff   = mag_x - ps_x;

    always_comb begin
      lam = diff[OUT_W-1:0];
      sat = 1'b0;
      if (SAT_EN != 0) begin
        unique case (1'b1)
          (diff > MAXV): begin
            lam = MAXV[OUT_W-1:0];
            sat = 1'b1;
          end
          (diff < MINV): begin
            lam = MINV[OUT_W-1:0];
            sat = 1'b1;
          end
          default: ;
        endcase
      end
    end

    assign c_lam[i*OUT_W +: OUT_W] = lam;
    assign c_sat[i]                = sat;
  end

  logic [N_DELAY-1:0] v_q;
  logic [LW-1:0]      d_q [N_DELAY];
  logic [LANES-1:0]   s_q [N_DELAY];

  assign out_valid  = v_q[N_DELAY-1];
  assign lambda_out = d_q[N_DELAY-1];
  assign sat_out    = s_q[N_DELAY-1];
  // one global enable: the whole pipe moves or the whole pipe holds
  assign adv        = !out_valid || out_ready;
  assign in_ready   = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < N_DELAY; k++) begin
        d_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q[0] <= in_valid;
      d_q[0] <= c_lam;
      s_q[0] <= c_sat;
      for (int k = 1; k < N_DELAY; k++) begin
        v_q[k] <= v_q[k-1];
        d_q[k] <= d_q[k-1];
        s_q[k] <= s_q[k-1];
      end
    end
  end

  logic hs_sat;
  assign hs_sat = out_valid && out_ready && (|sat_out);

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_count <= '0;
    end else if (hs_sat && !(&sat_count)) begin
      sat_count <= sat_count + SATCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lambda_minus_pipe.sv
// tb_lambda_minus_pipe: directed + random-backpressure bench for two
// 2-lane instances (saturating and wrapping) sharing one stimulus.
module tb_lambda_minus_pipe;

  localparam int L  = 2;
  localparam int ND = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          sat_clr = 1'b0;
  logic [L*14-1:0] mag_in = '0;
  logic [L*14-1:0] phi_in = '0;
  logic [L*8-1:0]  rho_in = '0;

  logic          in_ready, in_ready_w;
  logic          out_valid, out_valid_w;
  logic [L*14-1:0] lam_s, lam_w;
  logic [L-1:0]  sat_s, sat_w;
  logic [3:0]    cnt_s, cnt_w;

  always #5 clk = ~clk;

  lambda_minus_pipe #(.LANES(L), .SAT_EN(1), .SATCNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mag_in(mag_in), .phi_in(phi_in), .rho_in(rho_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .lambda_out(lam_s), .sat_out(sat_s),
    .sat_clr(sat_clr), .sat_count(cnt_s));

  lambda_minus_pipe #(.LANES(L), .SAT_EN(0), .SATCNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .mag_in(mag_in), .phi_in(phi_in), .rho_in(rho_in),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .lambda_out(lam_w), .sat_out(sat_w),
    .sat_clr(sat_clr), .sat_count(cnt_w));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int sl [L];
    bit ss [L];
    int wl [L];
  } exp_t;

  exp_t q[$];
  int   mcnt = 0;
  int   n_acc = 0;
  int   n_out = 0;

  function automatic int floor128(input int x);
    if (x >= 0) return x / 128;
    return -((-x + 127) / 128);
  endfunction

  function automatic exp_t model(input logic [L*14-1:0] m,
                                 input logic [L*8-1:0] r,
                                 input logic [L*14-1:0] p);
    exp_t e;
    for (int i = 0; i < L; i++) begin
      int mi, ri, pi, d, w;
      mi = int'($signed(m[i*14 +: 14]));
      ri = int'($signed(r[i*8 +: 8]));
      pi = int'(p[i*14 +: 14]);
      d  = mi - floor128(ri * pi);
      e.ss[i] = (d > 8191) || (d < -8192);
      e.sl[i] = (d > 8191) ? 8191 : (d < -8192) ? -8192 : d;
      w = ((d + 8192) % 16384 + 16384) % 16384 - 8192;
      e.wl[i] = w;
    end
    return e;
  endfunction

  function automatic int lane(input logic [L*14-1:0] v, input int i);
    return int'($signed(v[i*14 +: 14]));
  endfunction

  bit              stall_prev = 0;
  logic [L*14-1:0] prev_lam;
  logic [L-1:0]    prev_sat;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
      stall_prev = 0;
    end else begin
      chk("sat_count", cnt_s, mcnt);
      chk("sat_count_wrap", cnt_w, 0);
      chk("out_valid_pair", out_valid_w, out_valid);
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_lambda", lam_s, prev_lam);
        chk("stall_sat", sat_s, prev_sat);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          for (int i = 0; i < L; i++) begin
            chk("lambda_sat", lane(lam_s, i), q[0].sl[i]);
            chk("sat_flag", sat_s[i], q[0].ss[i]);
            chk("lambda_wrap", lane(lam_w, i), q[0].wl[i]);
            chk("sat_flag_wrap", sat_w[i], 0);
          end
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        if ((q[0].ss[0] || q[0].ss[1]) && mcnt < 15) mcnt++;
        void'(q.pop_front());
        n_out++;
      end
      if (sat_clr) mcnt = 0;
      if (in_valid && in_ready) begin
        q.push_back(model(mag_in, rho_in, phi_in));
        n_acc++;
        chk("in_flight_max", q.size() <= ND, 1);
      end
      stall_prev = out_valid && !out_ready;
      prev_lam   = lam_s;
      prev_sat   = sat_s;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int m, input int r, input int p);
    logic [31:0] mv, rv, pv;
    mv = m; rv = r; pv = p;
    mag_in[i*14 +: 14] = mv[13:0];
    rho_in[i*8 +: 8]   = rv[7:0];
    phi_in[i*14 +: 14] = pv[13:0];
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 40) begin
      step();
      n++;
    end
    chk("drain_done", q.size() == 0 && !out_valid, 1);
  endtask

  // one beat through an empty pipe; lane 0 checked against literals
  task automatic single(input string nm, input int m, input int r,
                        input int p, input int e_sl, input bit e_ss,
                        input int e_wl, input bit clr, input int e_cnt);
    int n = 0;
    drain();
    set_lane(0, m, r, p);
    set_lane(1, 768, 64, 512);
    in_valid = 1'b1;
    while (!out_valid && n < 20) begin
      step();
      n++;
      in_valid = 1'b0;
    end
    chk({nm, "_latency"}, n, ND);
    chk({nm, "_lambda"}, lane(lam_s, 0), e_sl);
    chk({nm, "_sat"}, sat_s[0], e_ss);
    chk({nm, "_wrap"}, lane(lam_w, 0), e_wl);
    chk({nm, "_lane1"}, lane(lam_s, 1), 512);
    sat_clr = clr;
    step();
    sat_clr = 1'b0;
    chk({nm, "_count"}, cnt_s, e_cnt);
  endtask

  initial begin
    int acc;
    int cyc;
    int out0;
    int sent;

    repeat (3) step();
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_count", cnt_s, 0);
    chk("reset_lambda", lam_s, 0);

    single("nominal", 768, 64, 512, 512, 0, 512, 0, 0);
    single("floor", 0, -1, 1, 1, 0, 1, 0, 0);
    single("sat_hi", 8191, -128, 16383, 8191, 1, 8190, 0, 1);
    single("sat_lo", -8192, 127, 16383, -8192, 1, -8063, 0, 2);
    single("clr_hit", 8191, -128, 16383, 8191, 1, 8190, 1, 0);

    // random backpressure
    drain();
    out0 = n_out;
    sent = 0;
    cyc  = 0;
    while ((n_out - out0) < 20 && cyc < 1000) begin
      in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      for (int i = 0; i < L; i++)
        set_lane(i, $urandom_range(0, 16383) - 8192,
                 $urandom_range(0, 255) - 128, $urandom_range(0, 16383));
      out_ready = $urandom_range(0, 1);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("random_outputs", n_out - out0, 20);
    chk("random_sent", sent, 20);
    drain();

    // out_ready low from empty: pipe fills to exactly ND
    acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_lane(0, k * 10, 3, k);
      set_lane(1, -k, -5, 100 + k);
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("fill_accepts", acc, ND);
    drain();

    // counter saturation: 18 clamped beats, clean start
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_lane(0, 8191, -128, 16383);
    set_lane(1, 0, 0, 0);
    repeat (18) step();
    drain();
    chk("count_saturate", cnt_s, 15);

    // reset with 3 beats in flight
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) acc++;
      step();
    end
    chk("flush_no_valid", acc, 0);
    chk("flush_count", cnt_s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
